// File: rtl/fwd_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit_if
// Brief    : Pipeline-side bundle for the forwarding / hazard unit.
// Revision : 1.0  initial release
// ============================================================================
interface fwd_hazard_unit_if #(
  parameter int REG_AW = 4,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*REG_AW-1:0] rdReg_ID;
  logic [NUM_RD-1:0]        rdEn_ID;
  logic [NUM_RD*REG_AW-1:0] rdReg_EX;
  logic [REG_AW-1:0]        wrReg_EX;
  logic [REG_AW-1:0]        wrReg_MEM;
  logic [REG_AW-1:0]        wrReg_WB;
  logic                     wrEn_EX;
  logic                     wrEn_MEM;
  logic                     wrEn_WB;
  logic                     memRd_EX;
  logic                     brTaken_EX;
  logic                     mem_busy;
  logic                     cnt_clr;
  logic [2*NUM_RD-1:0]      hazSel;
  logic                     stall_fd;
  logic                     bubble_ex;
  logic                     flush_fd;
  logic                     stall_all;
  logic [15:0]              stall_cnt;

  modport master (
    output rdReg_ID, rdEn_ID, rdReg_EX, wrReg_EX, wrReg_MEM, wrReg_WB,
           wrEn_EX, wrEn_MEM, wrEn_WB, memRd_EX, brTaken_EX, mem_busy, cnt_clr,
    input  hazSel, stall_fd, bubble_ex, flush_fd, stall_all, stall_cnt
  );

  modport slave (
    input  rdReg_ID, rdEn_ID, rdReg_EX, wrReg_EX, wrReg_MEM, wrReg_WB,
           wrEn_EX, wrEn_MEM, wrEn_WB, memRd_EX, brTaken_EX, mem_busy, cnt_clr,
    output hazSel, stall_fd, bubble_ex, flush_fd, stall_all, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Brief    : EX operand forwarding select plus load-use / branch / memory-wait
//            stall control. Optional stall counter under HAZ_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module fwd_hazard_unit #(
  parameter int REG_AW   = 4,
  parameter int NUM_RD   = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  fwd_hazard_unit_if.slave  hz
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    LDWAIT = 1'b1
  } state_t;

  localparam logic [2:0]        C_LD_RELOAD = 3'(LOAD_LAT - 1);
  localparam logic [REG_AW-1:0] C_ZERO_REG  = '0;

  state_t              r_state;
  state_t              w_stateNxt;
  logic [2:0]          r_ldCnt;
  logic [2:0]          w_ldCntNxt;
  logic [2*NUM_RD-1:0] w_hazSel;
  logic [NUM_RD-1:0]   w_useMatch;
  logic                w_loadUse;
  logic                w_stallFd;
  logic                w_flushFd;

  function automatic logic fwdHit(input logic en,
                                  input logic [REG_AW-1:0] dst,
                                  input logic [REG_AW-1:0] src);
    return en && (dst == src) && (dst != C_ZERO_REG);
  endfunction

  // Forward selects stay at regfile (11) throughout reset.
  always_comb begin
    w_hazSel   = '1;
    w_useMatch = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rst_n) begin
        if (fwdHit(hz.wrEn_MEM, hz.wrReg_MEM, hz.rdReg_EX[i*REG_AW +: REG_AW]))
          w_hazSel[2*i +: 2] = 2'b00;
        else if (fwdHit(hz.wrEn_WB, hz.wrReg_WB, hz.rdReg_EX[i*REG_AW +: REG_AW]))
          w_hazSel[2*i +: 2] = 2'b01;
      end
      w_useMatch[i] = hz.rdEn_ID[i] && (hz.rdReg_ID[i*REG_AW +: REG_AW] == hz.wrReg_EX);
    end
  end

  assign w_loadUse = hz.memRd_EX && hz.wrEn_EX && (hz.wrReg_EX != C_ZERO_REG) && (|w_useMatch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_ldCnt <= 3'd0;
    end else begin
      r_state <= w_stateNxt;
      r_ldCnt <= w_ldCntNxt;
    end
  end

  // Memory wait freezes everything; a taken branch beats any load-use stall.
  always_comb begin
    w_stateNxt = r_state;
    w_ldCntNxt = r_ldCnt;
    w_stallFd  = 1'b0;
    w_flushFd  = 1'b0;
    if (hz.mem_busy) begin
      w_stateNxt = r_state;
    end else if (hz.brTaken_EX) begin
      w_flushFd  = 1'b1;
      w_stateNxt = RUN;
      w_ldCntNxt = 3'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_loadUse) begin
            w_stallFd = 1'b1;
            if (LOAD_LAT > 1) begin
              w_stateNxt = LDWAIT;
              w_ldCntNxt = C_LD_RELOAD;
            end
          end
        end
        LDWAIT: begin
          w_stallFd = 1'b1;
          if (r_ldCnt <= 3'd1) begin
            w_stateNxt = RUN;
            w_ldCntNxt = 3'd0;
          end else begin
            w_ldCntNxt = r_ldCnt - 3'd1;
          end
        end
        default: begin
          w_stateNxt = RUN;
          w_ldCntNxt = 3'd0;
        end
      endcase
    end
  end

  assign hz.hazSel    = w_hazSel;
  assign hz.stall_fd  = rst_n && w_stallFd;
  assign hz.bubble_ex = rst_n && w_stallFd;
  assign hz.flush_fd  = rst_n && w_flushFd;
  assign hz.stall_all = rst_n && hz.mem_busy;

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] r_stallCnt;
  logic        w_cntInc;

  assign w_cntInc = (rst_n && w_stallFd) || (rst_n && hz.mem_busy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stallCnt <= 16'd0;
    else if (hz.cnt_clr)
      r_stallCnt <= 16'd0;
    else if (w_cntInc && (r_stallCnt != 16'hFFFF))
      r_stallCnt <= r_stallCnt + 16'd1;
  end

  assign hz.stall_cnt = r_stallCnt;
`else
  assign hz.stall_cnt = 16'd0;
`endif

endmodule
`default_nettype wire
